a2d_sched: RTL and testbench

- Round-robin scheduler that owns the 16-bit SPI master and sequences conversions on an external 12-bit A2D.
- Each channel takes two SPI transactions: the first sends the channel select, the second clocks the result out.
- Results are stored in per-channel registers read by the motor/assist logic.
- A scan runs on a free-running period timer or on a manual trigger.

---
 rtl/a2d_pkg.sv | 21 ++
 rtl/a2d_period_tmr.sv | 35 +++
 rtl/a2d_sched.sv | 153 +++++++++++++++
 tb/tb_a2d_sched.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared types, constants and command builder for the A2D scan scheduler
package a2d_pkg;

  localparam int          RES_W  = 12;
  localparam logic [15:0] CMD_RD = 16'h0000;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CNV  = 3'd1,
    WT1  = 3'd2,
    GAP  = 3'd3,
    RD   = 3'd4,
    WT2  = 3'd5
  } state_t;

  // The A2D latches the channel from bits [13:11] of the first frame.
  function automatic logic [15:0] ch_sel_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_period_tmr.sv
// rtl/a2d_period_tmr.sv - free-running scan period timer with a single pending-request flag
module a2d_period_tmr #(
  parameter int PERIOD_W = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic trig,
  input  logic start,
  output logic pending
);

  logic [PERIOD_W-1:0] cnt;
  logic                rollover;

  assign rollover = en && (&cnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + PERIOD_W'(1);
    end
  end

  // A request landing on the start cycle survives the clear, so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else begin
      pending <= (pending && !start) || rollover || trig;
    end
  end

endmodule

// File: rtl/a2d_sched.sv
// rtl/a2d_sched.sv - round-robin A2D scan scheduler driving a 16-bit SPI master (option: A2D_FILT_EN)
module a2d_sched
  import a2d_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int PERIOD_W = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    trig,
  output logic                    wrt,
  output logic [15:0]             cmd,
  input  logic                    done,
  input  logic [15:0]             rd_data,
  output logic [NUM_CH*RES_W-1:0] results,
  output logic                    busy,
  output logic                    scan_done
);

  state_t           state;
  state_t           nxt;
  logic [2:0]       ch;
  logic             wt_first;
  logic             wt_ok;
  logic             pending;
  logic             start;
  logic             capture;
  logic             last_ch;
  logic [15:0]      cmd_q;
  logic             scan_done_q;
  logic [RES_W-1:0] res_q [NUM_CH];
  logic [3:0]       unused_rd;

`ifdef A2D_FILT_EN
  logic [NUM_CH-1:0] seeded;

  function automatic logic [RES_W-1:0] avg_round(input logic [RES_W-1:0] a,
                                                 input logic [RES_W-1:0] b);
    logic [RES_W:0] s;
    s = {1'b0, a} + {1'b0, b} + {{RES_W{1'b0}}, 1'b1};
    return s[RES_W:1];
  endfunction
`endif

  assign unused_rd = rd_data[15:12];

  a2d_period_tmr #(
    .PERIOD_W (PERIOD_W)
  ) u_tmr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .trig    (trig),
    .start   (start),
    .pending (pending)
  );

  assign last_ch = (ch == 3'(NUM_CH - 1));
  // done is still the previous frame's sticky level on the first wait cycle.
  assign wt_ok   = !wt_first && done;
  assign start   = (state == IDLE) && pending;
  assign capture = (state == WT2) && wt_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (pending) nxt = CNV;
      CNV:     nxt = WT1;
      WT1:     if (wt_ok) nxt = GAP;
      GAP:     nxt = RD;
      RD:      nxt = WT2;
      WT2:     if (wt_ok) nxt = last_ch ? IDLE : CNV;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    wrt  = (state == CNV) || (state == RD);
    busy = (state != IDLE);
  end

  assign cmd       = cmd_q;
  assign scan_done = scan_done_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wt_first <= 1'b0;
    end else begin
      wt_first <= (state == CNV) || (state == RD);
    end
  end

  // cmd is loaded on the edge that enters CNV/RD so it is valid with wrt and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch          <= 3'd0;
      cmd_q       <= 16'h0000;
      scan_done_q <= 1'b0;
    end else begin
      scan_done_q <= capture && last_ch;
      if (start) begin
        ch    <= 3'd0;
        cmd_q <= ch_sel_cmd(3'd0);
      end else if (capture) begin
        if (last_ch) begin
          ch <= 3'd0;
        end else begin
          ch    <= ch + 3'd1;
          cmd_q <= ch_sel_cmd(ch + 3'd1);
        end
      end else if (state == GAP) begin
        cmd_q <= CMD_RD;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        res_q[i] <= '0;
      end
`ifdef A2D_FILT_EN
      seeded <= '0;
`endif
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (capture && (ch == 3'(i))) begin
`ifdef A2D_FILT_EN
          res_q[i]  <= seeded[i] ? avg_round(res_q[i], rd_data[RES_W-1:0])
                                 : rd_data[RES_W-1:0];
          seeded[i] <= 1'b1;
`else
          res_q[i]  <= rd_data[RES_W-1:0];
`endif
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_res
    assign results[RES_W*g +: RES_W] = res_q[g];
  end

endmodule

// File: tb/tb_a2d_sched.sv
// tb/tb_a2d_sched.sv - self-checking bench for a2d_sched with an SPI master model and scan scoreboard
module tb_a2d_sched;

  localparam int NUM_CH = 4;
  localparam int PW     = 4;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               en = 1'b0;
  logic               trig = 1'b0;
  logic               done = 1'b0;
  logic [15:0]        rd_data = 16'h0000;
  logic               wrt;
  logic [15:0]        cmd;
  logic [NUM_CH*12-1:0] results;
  logic               busy;
  logic               scan_done;

  always #5 clk = ~clk;

  a2d_sched #(
    .NUM_CH   (NUM_CH),
    .PERIOD_W (PW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .trig      (trig),
    .wrt       (wrt),
    .cmd       (cmd),
    .done      (done),
    .rd_data   (rd_data),
    .results   (results),
    .busy      (busy),
    .scan_done (scan_done)
  );

  int          vectors = 0;
  int          errors  = 0;
  int          cyc     = 0;
  logic [15:0] wr_q[$];
  int          wr_cyc_q[$];
  logic [15:0] rsp_q[$];
  int          sd_cnt = 0;
  int          sd_cyc = 0;
  logic        wrt_prev = 1'b0;
  int          phase = 0;
  int          lat = 0;
  bit          fix_en = 1'b0;
  logic [15:0] fix_val = 16'h0000;
  logic [11:0] exp_res[NUM_CH];
  bit          seeded[NUM_CH];

  // SPI master model: done stays at its old level through the first wait cycle, then answers.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      done     = 1'b0;
      phase    = 0;
      wrt_prev = 1'b0;
    end else begin
      if (wrt) begin
        vectors++;
        assert (wrt_prev === 1'b0) else begin
          errors++;
          $error("FAIL wrt_back_to_back observed=1 expected=0");
        end
        wr_q.push_back(cmd);
        wr_cyc_q.push_back(cyc);
        phase = 1;
        lat   = $urandom_range(1, 5);
      end else if (phase == 1) begin
        phase = 2;
      end else if (phase == 2) begin
        done = 1'b0;
        lat--;
        if (lat == 0) begin
          rd_data = fix_en ? fix_val : 16'($urandom);
          done    = 1'b1;
          rsp_q.push_back(rd_data);
          phase = 0;
        end
      end
      if (scan_done) begin
        sd_cnt++;
        sd_cyc = cyc;
      end
      wrt_prev = wrt;
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    wr_q.delete();
    wr_cyc_q.delete();
    rsp_q.delete();
    for (int k = 0; k < NUM_CH; k++) begin
      exp_res[k] = 12'h000;
      seeded[k]  = 1'b0;
    end
  endtask

  task automatic do_reset();
    en    = 1'b0;
    trig  = 1'b0;
    rst_n = 1'b0;
    tick();
    clear_model();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic pulse_trig();
    trig = 1'b1;
    tick();
    trig = 1'b0;
  endtask

  task automatic wait_sd(input string tag);
    int k = 0;
    do begin
      tick();
      k++;
    end while (scan_done !== 1'b1 && k < 3000);
    chk({tag, "_scan_done_seen"}, k < 3000, 1);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    int quiet_n = 0;
    while (quiet_n < 3 && k < 3000) begin
      tick();
      k++;
      quiet_n = (busy === 1'b0 && scan_done === 1'b0) ? quiet_n + 1 : 0;
    end
    chk({tag, "_idle_seen"}, k < 3000, 1);
  endtask

  task automatic quiet(input int n, input string tag);
    int s = wr_q.size();
    repeat (n) tick();
    chk({tag, "_no_wrt"}, wr_q.size(), s);
  endtask

  function automatic int first_cyc(input int idx);
    return (wr_cyc_q.size() > idx) ? wr_cyc_q[idx] : -1;
  endfunction

  // Expected results follow from the read-frame data alone: raw copy, or rounded average when filtered.
  task automatic check_scan(input int base, input string tag);
    logic [NUM_CH*12-1:0] exp_v;
    logic [11:0]          raw;
    bit                   enough;
    enough = (wr_q.size() >= base + 2*NUM_CH) && (rsp_q.size() >= base + 2*NUM_CH);
    chk({tag, "_frames"}, enough, 1);
    if (!enough) return;
    for (int k = 0; k < NUM_CH; k++) begin
      chk($sformatf("%s_sel_cmd%0d", tag, k), wr_q[base + 2*k], {2'b00, 3'(k), 11'h000});
      chk($sformatf("%s_rd_cmd%0d", tag, k), wr_q[base + 2*k + 1], 16'h0000);
      raw = rsp_q[base + 2*k + 1][11:0];
`ifdef A2D_FILT_EN
      if (seeded[k]) exp_res[k] = 12'((int'(exp_res[k]) + int'(raw) + 1) / 2);
      else           exp_res[k] = raw;
`else
      exp_res[k] = raw;
`endif
      seeded[k] = 1'b1;
      exp_v[12*k +: 12] = exp_res[k];
    end
    chk({tag, "_results"}, results, exp_v);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    int base;
    int sdp;
    int sd0;
    int k;

    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_wrt", wrt, 0);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_results", results, 0);
    chk("rst_busy", busy, 0);
    chk("rst_scan_done", scan_done, 0);
    clear_model();
    rst_n = 1'b1;
    tick();

    // Manual trigger with a fixed read value
    fix_en  = 1'b1;
    fix_val = 16'h0ABC;
    t0 = cyc;
    pulse_trig();
    wait_sd("t1");
    chk("t1_latency", first_cyc(0), t0 + 2);
    chk("t1_wrt_count", wr_q.size(), 2*NUM_CH);
    check_scan(0, "t1");
    chk("t1_all_abc", results, {NUM_CH{12'hABC}});
    chk("t1_scan_done_count", sd_cnt, 1);
    tick();
    chk("t1_busy_after", busy, 0);
    chk("t1_scan_done_pulse", scan_done, 0);

    // Random data, stale done levels between frames
    fix_en = 1'b0;
    base = wr_q.size();
    pulse_trig();
    wait_sd("t2");
    check_scan(base, "t2");

    // Two mid-scan triggers collapse to one; a trigger on the scan_done cycle adds exactly one
    sd0  = sd_cnt;
    base = wr_q.size();
    pulse_trig();
    repeat (10) tick();
    pulse_trig();
    repeat (3) tick();
    pulse_trig();
    wait_sd("t3a");
    check_scan(base, "t3a");
    sdp = sd_cyc;
    wait_sd("t3b");
    chk("t3b_restart", first_cyc(base + 2*NUM_CH), sdp + 1);
    check_scan(base + 2*NUM_CH, "t3b");
    sdp = sd_cyc;
    pulse_trig();
    wait_sd("t3c");
    chk("t3c_restart", first_cyc(base + 4*NUM_CH), sdp + 2);
    check_scan(base + 4*NUM_CH, "t3c");
    quiet(60, "t3");
    chk("t3_scan_count", sd_cnt - sd0, 3);

    // Reset while waiting for channel 2's read frame
    base = wr_q.size();
    pulse_trig();
    k = 0;
    while (wr_q.size() < base + 6 && k < 500) begin
      tick();
      k++;
    end
    chk("t4_reached_rd2", k < 500, 1);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t4_rst_wrt", wrt, 0);
    chk("t4_rst_cmd", cmd, 16'h0000);
    chk("t4_rst_results", results, 0);
    chk("t4_rst_busy", busy, 0);
    chk("t4_rst_scan_done", scan_done, 0);
    do_reset();
    pulse_trig();
    wait_sd("t4");
    check_scan(0, "t4");

    // Period timer: first rollover after 2**PW enabled cycles, back-to-back scans afterwards
    do_reset();
    en = 1'b1;
    t0 = cyc;
    wait_sd("t5a");
    chk("t5a_first_wrt", first_cyc(0), t0 + (1 << PW) + 1);
    check_scan(0, "t5a");
    sdp = sd_cyc;
    wait_sd("t5b");
    chk("t5b_restart", first_cyc(2*NUM_CH), sdp + 1);
    check_scan(2*NUM_CH, "t5b");
    en = 1'b0;
    wait_idle("t5");
    quiet(60, "t5");

    // Trigger coinciding with a rollover is one request
    do_reset();
    en = 1'b1;
    t0 = cyc;
    repeat ((1 << PW) - 1) tick();
    trig = 1'b1;
    tick();
    trig = 1'b0;
    en   = 1'b0;
    sd0  = sd_cnt;
    wait_sd("t6");
    chk("t6_first_wrt", first_cyc(0), t0 + (1 << PW) + 1);
    check_scan(0, "t6");
    quiet(60, "t6");
    chk("t6_scan_count", sd_cnt - sd0, 1);

    // Two captures of known values into every channel
    do_reset();
    fix_en  = 1'b1;
    fix_val = 16'hF100;
    pulse_trig();
    wait_sd("t7a");
    check_scan(0, "t7a");
    chk("t7a_ch0", results[11:0], 12'h100);
    fix_val = 16'h0200;
    pulse_trig();
    wait_sd("t7b");
    check_scan(2*NUM_CH, "t7b");
`ifdef A2D_FILT_EN
    chk("t7b_ch0", results[11:0], 12'h180);
`else
    chk("t7b_ch0", results[11:0], 12'h200);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
